// File: rtl/usensor_echo_responder.sv
// Ultrasonic sensor emulator: answers a valid trigger pulse with an echo whose
// width in clock cycles equals the programmed distance (0 means "no object").
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for synchronized trig high; width counter cleared
// S_TRIG_HI | measuring trig high width, decide accept/reject on its fall
// S_DELAY   | echo lead-in delay after an accepted trigger
// S_ECHO    | echo driven high for the latched length
// S_HOLDOFF | quiet period after echo; triggers ignored
module usensor_echo_responder #(
    parameter int MIN_TRIG      = 500,
    parameter int ECHO_DELAY    = 1000,
    parameter int NO_OBJ_CYCLES = 1900000,
    parameter int HOLDOFF       = 3000000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        trig,
    input  logic [20:0] distance,
    output logic        echo,
    output logic        busy,
    output logic        short_trig,
    output logic [7:0]  ping_count
);
    localparam int LW  = (NO_OBJ_CYCLES > 2097151) ? $clog2(NO_OBJ_CYCLES + 1) : 21;
    localparam int HW  = $clog2(HOLDOFF + 1);
    localparam int DW  = $clog2(ECHO_DELAY + 1);
    localparam int CW0 = (LW > HW) ? LW : HW;
    localparam int CW  = (CW0 > DW) ? CW0 : DW;
    localparam int WW  = $clog2(MIN_TRIG + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_DELAY,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, trig_s;
    logic [WW-1:0] width, width_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] echo_len, len_nxt, len_now;
    logic          short_nxt;

    assign len_now = (distance == '0) ? CW'(NO_OBJ_CYCLES) : CW'(distance);
    assign busy    = (state == S_DELAY) || (state == S_ECHO) || (state == S_HOLDOFF);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1      <= 1'b0;
            trig_s     <= 1'b0;
            state      <= S_IDLE;
            width      <= '0;
            cnt        <= '0;
            echo_len   <= '0;
            echo       <= 1'b0;
            short_trig <= 1'b0;
            ping_count <= 8'd0;
        end else begin
            sync1      <= trig;
            trig_s     <= sync1;
            state      <= state_nxt;
            width      <= width_nxt;
            cnt        <= cnt_nxt;
            echo_len   <= len_nxt;
            echo       <= (state_nxt == S_ECHO);
            short_trig <= short_nxt;
            if (state_nxt == S_ECHO && state != S_ECHO)
                ping_count <= ping_count + 8'd1;
        end
    end

    // Counter loads are "remaining cycles after this one", so each state
    // exits on terminal count zero.
    always_comb begin
        state_nxt = state;
        width_nxt = width;
        cnt_nxt   = cnt;
        len_nxt   = echo_len;
        short_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                width_nxt = '0;
                if (trig_s) begin
                    width_nxt = WW'(1);
                    state_nxt = S_TRIG_HI;
                end
            end
            S_TRIG_HI: begin
                if (trig_s) begin
                    if (width < WW'(MIN_TRIG))
                        width_nxt = width + WW'(1);
                end else if (width >= WW'(MIN_TRIG)) begin
                    len_nxt = len_now;
                    if (ECHO_DELAY == 1) begin
                        state_nxt = S_ECHO;
                        cnt_nxt   = len_now - CW'(1);
                    end else begin
                        state_nxt = S_DELAY;
                        cnt_nxt   = CW'(ECHO_DELAY - 2);
                    end
                end else begin
                    short_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_nxt = S_ECHO;
                    cnt_nxt   = echo_len - CW'(1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_ECHO: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLDOFF;
                    cnt_nxt   = CW'(HOLDOFF - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_HOLDOFF: begin
                if (cnt == '0)
                    state_nxt = S_IDLE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_usensor_echo_responder.sv
// Bench for usensor_echo_responder: directed and random pings checked against
// timing predicted from trigger release cycles; a small-parameter copy covers wrap.
module tb_usensor_echo_responder;
    localparam int MIN_TRIG   = 500;
    localparam int ECHO_DELAY = 100;
    localparam int HOLDOFF    = 200;
    localparam int NO_OBJ     = 5000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        trig = 1'b0;
    logic        trig_w = 1'b0;
    logic [20:0] distance = '0;
    logic [20:0] dist_w = '0;
    logic        echo, busy, short_trig;
    logic        echo_w, busy_w, short_w;
    logic [7:0]  ping_count, ping_count_w;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int pc_model = 0;

    int rise_cyc[$], rise_pc[$], width_q[$], brise[$], bfall[$], sstart[$];
    int w_rise[$], w_width[$];
    int short_pulses = 0, short_bad = 0, srun = 0, e_start = 0, w_start = 0, w_short = 0;
    logic echo_p = 1'b0, busy_p = 1'b0, echo_wp = 1'b0;

    usensor_echo_responder #(
        .MIN_TRIG(MIN_TRIG), .ECHO_DELAY(ECHO_DELAY),
        .NO_OBJ_CYCLES(NO_OBJ), .HOLDOFF(HOLDOFF)
    ) dut (
        .clock(clock), .resetn(resetn), .trig(trig), .distance(distance),
        .echo(echo), .busy(busy), .short_trig(short_trig), .ping_count(ping_count)
    );

    usensor_echo_responder #(
        .MIN_TRIG(4), .ECHO_DELAY(1), .NO_OBJ_CYCLES(20), .HOLDOFF(3)
    ) dut_w (
        .clock(clock), .resetn(resetn), .trig(trig_w), .distance(dist_w),
        .echo(echo_w), .busy(busy_w), .short_trig(short_w), .ping_count(ping_count_w)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (echo && !echo_p) begin
            rise_cyc.push_back(cyc);
            rise_pc.push_back(int'(ping_count));
            e_start = cyc;
        end
        if (!echo && echo_p) width_q.push_back(cyc - e_start);
        if (busy && !busy_p) brise.push_back(cyc);
        if (!busy && busy_p) bfall.push_back(cyc);
        if (short_trig) begin
            if (srun == 0) sstart.push_back(cyc);
            srun++;
        end else if (srun > 0) begin
            short_pulses++;
            if (srun != 1) short_bad++;
            srun = 0;
        end
        if (echo_w && !echo_wp) begin
            w_rise.push_back(cyc);
            w_start = cyc;
        end
        if (!echo_w && echo_wp) w_width.push_back(cyc - w_start);
        if (short_w) w_short++;
        echo_p  = echo;
        busy_p  = busy;
        echo_wp = echo_w;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse(input int sel, input int n, output int k);
        if (sel == 0) trig = 1'b1; else trig_w = 1'b1;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        if (sel == 0) trig = 1'b0; else trig_w = 1'b0;
        k = cyc;
    endtask

    // Expected timing: trig released after edge k reaches trig_s two edges
    // later (cycle E = k+2); echo rises at E+ECHO_DELAY.
    task automatic do_ping(input int n, input int d);
        int k, len, r0, w0, b0, f0, s0, ss0;
        r0 = rise_cyc.size(); w0 = width_q.size(); b0 = brise.size();
        f0 = bfall.size(); s0 = short_pulses; ss0 = sstart.size();
        distance = 21'(d);
        pulse(0, n, k);
        if (n >= MIN_TRIG) begin
            len = (d == 0) ? NO_OBJ : d;
            pc_model = (pc_model + 1) % 256;
            to_cyc(k + ECHO_DELAY + 2 + len + HOLDOFF + 5);
            chk("echo_count", rise_cyc.size() - r0, 1);
            chk("echo_rise", (rise_cyc.size() > r0) ? rise_cyc[r0] : -1, k + ECHO_DELAY + 2);
            chk("echo_width", (width_q.size() > w0) ? width_q[w0] : -1, len);
            chk("ping_count", (rise_pc.size() > r0) ? rise_pc[r0] : -1, pc_model);
            chk("busy_rise", (brise.size() > b0) ? brise[b0] : -1, k + 3);
            chk("busy_fall", (bfall.size() > f0) ? bfall[f0] : -1, k + ECHO_DELAY + 2 + len + HOLDOFF);
            chk("no_short", short_pulses - s0, 0);
        end else begin
            to_cyc(k + 10);
            chk("rej_echo", rise_cyc.size() - r0, 0);
            chk("rej_busy", brise.size() - b0, 0);
            chk("short_count", short_pulses - s0, 1);
            chk("short_cycle", (sstart.size() > ss0) ? sstart[ss0] : -1, k + 3);
            chk("short_width", short_bad, 0);
        end
    endtask

    initial begin
        int k1, k3, bend, meas, r0, w0, b0, f0, s0, ss0, n, d, k;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_echo", echo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_short", short_trig, 0);
        chk("rst_pc", ping_count, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        do_ping(600, 1234);
        do_ping(499, 1234);
        do_ping(500, 321);
        do_ping(600, 0);

        // Triggers during ECHO and HOLDOFF; the late one is only measured from IDLE.
        r0 = rise_cyc.size(); w0 = width_q.size(); b0 = brise.size();
        f0 = bfall.size(); s0 = short_pulses; ss0 = sstart.size();
        distance = 21'd1000;
        pulse(0, 600, k1);
        pc_model = (pc_model + 1) % 256;
        bend = k1 + ECHO_DELAY + 2 + 1000 + HOLDOFF;
        to_cyc(k1 + 200); trig = 1'b1;
        to_cyc(k1 + 300); distance = 21'd7;
        to_cyc(k1 + 800); trig = 1'b0;
        to_cyc(k1 + 1150); trig = 1'b1;
        to_cyc(k1 + 1750); trig = 1'b0;
        k3 = cyc;
        meas = k3 + 2 - bend;
        to_cyc(k3 + 20);
        chk("ign_echo_count", rise_cyc.size() - r0, 1);
        chk("ign_width", (width_q.size() > w0) ? width_q[w0] : -1, 1000);
        chk("ign_busy_count", brise.size() - b0, 1);
        chk("ign_busy_fall", (bfall.size() > f0) ? bfall[f0] : -1, bend);
        chk("ign_pc", ping_count, pc_model);
        chk("ign_short_count", short_pulses - s0, (meas < MIN_TRIG) ? 1 : 0);
        chk("ign_short_cycle", (sstart.size() > ss0) ? sstart[ss0] : -1, k3 + 3);

        for (int i = 0; i < 6; i++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 499)) : int'($urandom_range(500, 700));
            d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 2500));
            do_ping(n, d);
        end

        // Asynchronous reset in the middle of an echo.
        distance = 21'd500;
        pulse(0, 600, k);
        to_cyc(k + ECHO_DELAY + 2 + 50);
        chk("pre_rst_echo", echo, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_echo", echo, 0);
        chk("mid_rst_pc", ping_count, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        pc_model = 0;
        repeat (2) @(posedge clock);
        #1;
        do_ping(600, 50);

        for (int i = 0; i < 256; i++) begin
            dist_w = 21'd10;
            pulse(1, 4, k);
            to_cyc(k + 1 + 2 + 10 + 3 + 3);
            chk("wrap_rise", (w_rise.size() > i) ? w_rise[i] : -1, k + 3);
            chk("wrap_width", (w_width.size() > i) ? w_width[i] : -1, 10);
            chk("wrap_pc", ping_count_w, (i + 1) % 256);
        end
        chk("wrap_busy", busy_w, 0);
        chk("wrap_short", w_short, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/usensor_echo_responder.md
# usensor_echo_responder

Synthesizable responder for the ultrasonic ranging interface: it plays the sensor's role. It accepts a trigger pulse from the ranging initiator and answers with an echo pulse whose width in clock cycles equals a programmed distance value. It sits on the GPIO trig/echo pins, or directly on an initiator's trig/echo nets in simulation, so the ranging path can be exercised on-board without a physical transducer.

## Interface
- MIN_TRIG, 500: minimum trigger high width in clock cycles for a valid ping (10 µs at 50 MHz).
- ECHO_DELAY, 1000: cycles from the accepted trigger falling edge to echo rising; must be ≥ 1.
- NO_OBJ_CYCLES, 1900000: echo width emitted when distance is 0, emulating "no object" (38 ms).
- HOLDOFF, 3000000: cycles after echo falls during which triggers are ignored.
- clock  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous, active-low reset.
- trig  in  1  trigger from initiator; asynchronous to clock.
- distance  in  21  echo width to emit in cycles; sampled once per ping.
- echo  out  1  echo pulse to initiator; registered.
- busy  out  1  high in any state other than IDLE/TRIG_HI.
- short_trig  out  1  one-cycle pulse when a trigger shorter than MIN_TRIG is rejected.
- ping_count  out  8  count of echo pulses emitted; wraps 255→0.

## Operation
- trig passes through a 2-flop synchronizer (trig_s). All decisions use trig_s and its previous value.
- States:
  - IDLE: clear the width counter. trig_s=1 → TRIG_HI with width=1.
  - TRIG_HI: width increments each cycle while trig_s=1, saturating at MIN_TRIG. On trig_s falling:
    - width ≥ MIN_TRIG: latch echo_len = (distance==0 ? NO_OBJ_CYCLES : distance), then → DELAY.
    - Otherwise: pulse short_trig, then → IDLE.
  - DELAY: count ECHO_DELAY cycles, then → ECHO.
  - ECHO: echo=1 for exactly echo_len cycles, then → HOLDOFF.
  - HOLDOFF: count HOLDOFF cycles, then → IDLE. trig is ignored throughout.
- Triggers arriving during DELAY, ECHO or HOLDOFF are ignored entirely. They produce no short_trig and are not queued.
- If trig_s is still high when HOLDOFF ends, IDLE sees it on the next cycle and width counting starts from there. A trigger already in progress is measured only from that point.
- distance changes after the latch cycle do not affect the current echo.
- ping_count increments on the cycle echo rises.
- Counters are sized for the larger of NO_OBJ_CYCLES and 2^21−1, and for HOLDOFF. Arithmetic is unsigned and never wraps within a state.

## Timing
- Reset values: echo=0, busy=0, short_trig=0, ping_count=0, state=IDLE, synchronizer flops=0.
- Reset is asynchronous: asserting resetn mid-echo drops echo in the same instant. After deassertion the block is in IDLE and needs a fresh full trigger.
- trig to trig_s latency: 2 cycles. Falling-edge detection happens on the first cycle trig_s=0.
- Call the edge-detect cycle E. The latch happens at E, and busy=1 from E+1.
- echo is high from cycle E+ECHO_DELAY through E+ECHO_DELAY+echo_len−1 inclusive. ping_count updates at E+ECHO_DELAY.
- busy falls HOLDOFF cycles after echo falls.
- short_trig is high for the single cycle following the rejected falling edge.
- Boundary widths:
  - Trigger width exactly MIN_TRIG synchronized cycles: accepted.
  - MIN_TRIG−1: rejected.
- distance = 2^21−1 yields a full-width echo with no truncation.

## Test plan
Bench parameters: MIN_TRIG=500, ECHO_DELAY=100, HOLDOFF=200, NO_OBJ_CYCLES=5000.
- Valid ping: trig high 600 cycles, distance=1234 → echo rises 100 cycles after the edge detect and stays high exactly 1234 cycles. ping_count=1, short_trig never asserted.
- Width boundary: trig high 499 cycles → short_trig one-cycle pulse, echo stays 0, busy stays 0. Then trig high 500 cycles → echo produced.
- No object: distance=0, valid trigger → echo width exactly 5000 cycles.
- Ignored triggers: a second 600-cycle trig issued during ECHO, and a third during HOLDOFF → no extra echo, ping_count increments by 1 only. distance changed to 7 mid-echo → current width unchanged.
- Reset mid-operation: resetn low for 3 cycles during ECHO → echo=0 immediately, ping_count=0. The next valid trigger with distance=50 yields a 50-cycle echo.
- Wrap: 256 valid pings with distance=10 → ping_count returns to 0.
